fp_add_scheduler: RTL and testbench
===================================

# fp_add_scheduler

Round-robin scheduler that shares one combinational single-precision floating-point adder among `NUM_REQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and drives the shared adder from a registered issue stage. Each sum returns on a single tagged response channel with backpressure. It sits between the requesting compute units and the adder instance, which is connected externally through the `add_*` ports.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 2–16.
- `ID_W`, `$clog2(NUM_REQ)`: localparam, width of the requester tag.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  bit i: requester i presents an operand pair.
- `req_ready`  out  NUM_REQ  bit i: requester i's pair is accepted this cycle; one-hot or zero.
- `req_a`  in  NUM_REQ*32  operand A, requester i at bits [32i+31:32i].
- `req_b`  in  NUM_REQ*32  operand B, same packing as `req_a`.
- `rsp_valid`  out  1  response held in the output register.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  ID_W  requester that issued the response.
- `rsp_result`  out  32  IEEE-754 single-precision sum.
- `add_a`  out  32  operand A to the shared adder; registered.
- `add_b`  out  32  operand B to the shared adder; registered.
- `add_result`  in  32  combinational sum from the shared adder.

## Operation
- Pipeline has two registered stages:
  - Issue stage S1: `s1_valid`, `add_a`, `add_b`, `s1_id`.
  - Output stage S2: `rsp_valid`, `rsp_result`, `rsp_id`.
- S2 update:
  - S2 loads `add_result` and `s1_id` when `s1_valid` is high and S2 can load.
  - S2 can load when `!rsp_valid || rsp_ready`.
  - S2 clears when it drains and S1 is empty.
- S1 advance: S1 can accept when `!s1_valid` or S1 moves into S2 this cycle.
- Arbitration is round-robin with a priority pointer `ptr`, range 0..NUM_REQ-1.
  - Winner: the first i with `req_valid[i]`, scanning i = ptr, ptr+1, … modulo NUM_REQ.
  - `req_ready[winner]` is high only when S1 can accept. All other `req_ready` bits are low.
- On a handshake (`req_valid[i] && req_ready[i]`):
  - S1 loads `req_a[i]`, `req_b[i]`, and tag i.
  - `ptr` becomes i+1, wrapping from NUM_REQ-1 to 0.
- `ptr` is unchanged when no handshake occurs.
- `req_ready` may depend combinationally on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- A requester must hold `req_valid` and its operands stable until accepted.
- The block performs no arithmetic. Results are whatever the shared adder produces for the issued operands.
- Responses return in acceptance order, with no reordering.
- Reset values:
  - `s1_valid`=0, `rsp_valid`=0, `ptr`=0.
  - `add_a`=`add_b`=0, `rsp_result`=0, `rsp_id`=0, `req_ready`=0.
- An assertion of `rst_n` mid-operation discards S1 and S2 contents. No response is produced for discarded pairs.

## Timing
- Latency: a handshake at edge N presents operands on `add_*` from N+1. `rsp_valid` rises after edge N+2.
- Throughput: one operation per cycle while `rsp_ready` is held high.
- `rsp_valid` high with `rsp_ready` low:
  - S2 holds `rsp_result`/`rsp_id` stable.
  - S1 keeps `add_a`/`add_b` stable.
  - At most one new pair is accepted, and only while S1 is empty.
  - `req_ready` is then all zero.
- Drain and refill in the same cycle is allowed:
  - When S2 drains and S1 advances in the same edge, a new request is accepted in that edge.
  - No bubble is inserted.
- With a single persistent requester, it is granted every cycle that S1 can accept.
- Starvation bound: a valid request is granted within NUM_REQ accepted handshakes.

## Structure
- Shared package `fp_sched_pkg` holds:
  - `FP_W`=32.
  - `fp_word_t` (logic [FP_W-1:0]).
  - The round-robin next-pointer function.
- Sub-module `rr_arbiter`:
  - Parameterised by N.
  - Inputs: `req`, `ptr`, `en`.
  - Outputs: one-hot `gnt` and `gnt_idx`.
  - Purely combinational. `ptr` is registered in `fp_add_scheduler`.
- The shared adder is external. The bench connects the team's single-precision adder to `add_a`/`add_b`/`add_result`.

## Test plan
- Reset with all requesters valid: all outputs 0 during reset. The first grant after release goes to requester 0.
- Single op: requester 2 sends 0x3F800000 + 0x40000000. Expect `rsp_valid` two cycles after the handshake, with `rsp_result`=0x40400000 and `rsp_id`=2.
- All 4 requesters continuously valid, `rsp_ready`=1:
  - Grants run 0,1,2,3,0,… with one per cycle.
  - `rsp_id` follows the same order, 2 cycles later.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after the first response.
  - Exactly one more pair is accepted, then `req_ready`=0.
  - `rsp_result`/`rsp_id` are held stable.
  - On release, the two results arrive back to back with no loss.
- Pointer wrap with sparse requests: requesters 3 and 1 valid, `ptr`=2.
  - Grant 3 first, then 1.
  - `ptr` ends at 2.
- Reset mid-stream with S1 and S2 full: assert `rst_n`=0.
  - `rsp_valid` drops immediately.
  - After release, no stale response appears and `ptr`=0.

Source files
------------

// File: rtl/fp_sched_pkg.sv
// Shared definitions for the floating-point adder scheduler.
//   FP_W         : width of an IEEE-754 single-precision word
//   fp_word_t    : one single-precision word
//   rr_next_ptr  : round-robin pointer advance (idx+1, wrapping at n)
package fp_sched_pkg;

  localparam int FP_W = 32;

  typedef logic [FP_W-1:0] fp_word_t;

  function automatic int unsigned rr_next_ptr(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The search starts at ptr and wraps
// modulo N; the first requester found wins.
//   req     : request vector
//   ptr     : highest-priority index (registered by the caller)
//   en      : grant enable; when low gnt is all zero
//   gnt     : one-hot grant (zero when disabled or nothing requested)
//   gnt_idx : index of the winning requester (valid whenever any req is set)
module rr_arbiter
  import fp_sched_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
    gnt = '0;
    if (en && found) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/fp_add_scheduler.sv
// Shares one external combinational FP32 adder among NUM_REQ requesters.
// Operand pairs are accepted round-robin into a registered issue stage
// (S1: s1_valid/add_a/add_b/s1_id) and the adder sum is captured into a
// registered output stage (S2: rsp_valid/rsp_result/rsp_id).
//   clk, rst_n         : clock, async active-low reset
//   req_valid/ready    : per-requester handshake (ready is one-hot or zero)
//   req_a, req_b       : packed operands, requester i at [32i+31:32i]
//   rsp_valid/ready    : tagged response handshake
//   rsp_id, rsp_result : requester tag and sum
//   add_a, add_b       : registered operands to the shared adder
//   add_result         : combinational sum from the shared adder
module fp_add_scheduler
  import fp_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output fp_word_t                rsp_result,
  output fp_word_t                add_a,
  output fp_word_t                add_b,
  input  fp_word_t                add_result
);

  logic               s1_valid;
  logic [ID_W-1:0]    s1_id;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  fp_word_t           sel_a;
  fp_word_t           sel_b;
  logic               s2_load;
  logic               s1_move;
  logic               s1_accept;
  logic               hs;

  assign s2_load   = !rsp_valid || rsp_ready;
  assign s1_move   = s1_valid && s2_load;
  assign s1_accept = !s1_valid || s1_move;

  // rst_n gates the grant so req_ready reads zero while reset is held,
  // even though the empty S1 would otherwise be ready to accept.
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .en      (s1_accept && rst_n),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign hs        = |gnt;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_a = req_a[i*FP_W +: FP_W];
        sel_b = req_b[i*FP_W +: FP_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      add_a    <= '0;
      add_b    <= '0;
      s1_id    <= '0;
      ptr      <= '0;
    end else begin
      if (hs) begin
        s1_valid <= 1'b1;
        add_a    <= sel_a;
        add_b    <= sel_b;
        s1_id    <= gnt_idx;
        ptr      <= ID_W'(rr_next_ptr(32'(gnt_idx), NUM_REQ));
      end else if (s1_move) begin
        // operands stay on add_a/add_b; only the valid flag drops
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_id     <= '0;
    end else if (s2_load) begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_result <= add_result;
        rsp_id     <= s1_id;
      end
    end
  end

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Self-checking bench for fp_add_scheduler: a behavioural FP32 adder model
// stands in for the shared adder; a monitor checks round-robin grants
// against a pointer model and pops expected responses from a scoreboard.
module tb_fp_add_scheduler;

  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [31:0]     rsp_result;
  logic [31:0]     add_a;
  logic [31:0]     add_b;
  logic [31:0]     add_result;

  always #5 clk = ~clk;

  fp_add_scheduler #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_result (add_result)
  );

  // FP32 <-> real conversion for zero and normal numbers
  function automatic real fp2r(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e;
    if (f[30:0] == 31'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    d = {f[31], e, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2fp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] int_to_fp(input int x);
    return r2fp(real'(x));
  endfunction

  // stand-in for the shared adder
  always_comb add_result = r2fp(fp2r(add_a) + fp2r(add_b));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [IW-1:0] id;
    logic [31:0]   res;
  } exp_t;

  exp_t sb[$];
  int   op_x[N];
  int   op_y[N];
  int   mptr = 0;

  // monitor: arbitration model + scoreboard
  always @(negedge clk) begin : monitor
    logic [N-1:0] hs;
    int   w;
    int   j;
    exp_t e;
    if (rst_n) begin
      check("req_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      hs = req_valid & req_ready;
      if (hs != '0) begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          j = (mptr + k) % N;
          if (w < 0 && req_valid[j]) w = j;
        end
        check("grant_rr", 32'(hs), 32'(1) << w);
        e.id  = IW'(w);
        e.res = int_to_fp(op_x[w] + op_y[w]);
        sb.push_back(e);
        mptr = (w + 1) % N;
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(e.id));
          check("rsp_result", rsp_result, e.res);
        end
      end
    end
  end

  always @(negedge rst_n) begin
    sb.delete();
    mptr = 0;
  end

  logic [N-1:0] acc;

  task automatic cyc_neg();
    @(negedge clk);
    acc = req_valid & req_ready;
  endtask

  task automatic cyc_pos();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc;
  endtask

  task automatic tick();
    cyc_neg();
    cyc_pos();
  endtask

  task automatic set_req(input int i, input int x, input int y);
    op_x[i] = x;
    op_y[i] = y;
    req_a[i*32 +: 32] = int_to_fp(x);
    req_b[i*32 +: 32] = int_to_fp(y);
    req_valid[i] = 1'b1;
  endtask

  task automatic set_rand(input int i);
    set_req(i, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    repeat (n) tick();
  endtask

  logic [31:0]   held_res;
  logic [IW-1:0] held_id;
  int            cnt;

  initial begin
    rst_n     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    acc       = '0;
    #2 rst_n  = 1'b0;

    // reset with everyone requesting
    for (int i = 0; i < N; i++) set_rand(i);
    repeat (2) tick();
    cyc_neg();
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_add_a", add_a, 32'd0);
    check("rst_add_b", add_b, 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    cyc_pos();
    rst_n = 1'b1;

    // first grant to requester 0, then continuous full-rate traffic
    cyc_neg();
    check("first_grant", 32'(req_ready), 32'b0001);
    cyc_pos();
    for (int i = 0; i < N; i++) if (!req_valid[i]) set_rand(i);
    for (int c = 0; c < 12; c++) begin
      cyc_neg();
      check("no_bubble", 32'(|acc), 32'd1);
      cyc_pos();
      for (int i = 0; i < N; i++) if (!req_valid[i]) set_rand(i);
    end
    idle(5);

    // single op from requester 2: 1.0 + 2.0
    set_req(2, 1, 2);
    cyc_neg();
    check("single_grant", 32'(req_ready), 32'b0100);
    cyc_pos();
    cyc_neg();
    check("single_add_a", add_a, 32'h3F800000);
    check("single_add_b", add_b, 32'h40000000);
    check("single_rsp_early", 32'(rsp_valid), 32'd0);
    cyc_pos();
    cyc_neg();
    check("single_rsp_valid", 32'(rsp_valid), 32'd1);
    check("single_rsp_result", rsp_result, 32'h40400000);
    check("single_rsp_id", 32'(rsp_id), 32'd2);
    cyc_pos();
    idle(3);

    // backpressure from an empty pipeline
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) set_rand(i);
    cnt      = 0;
    held_res = '0;
    held_id  = '0;
    for (int c = 0; c < 7; c++) begin
      cyc_neg();
      cnt += $countones(acc);
      if (c == 2) begin
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        held_res = rsp_result;
        held_id  = rsp_id;
      end
      if (c > 2) begin
        check("bp_hold_result", rsp_result, held_res);
        check("bp_hold_id", 32'(rsp_id), 32'(held_id));
      end
      if (c >= 2) check("bp_req_ready_zero", 32'(req_ready), 32'd0);
      cyc_pos();
    end
    check("bp_accept_count", 32'(cnt), 32'd2);
    rsp_ready = 1'b1;
    cyc_neg();
    check("bp_release_rsp1", 32'(rsp_valid), 32'd1);
    check("bp_refill_same_cycle", 32'(|acc), 32'd1);
    cyc_pos();
    cyc_neg();
    check("bp_release_rsp2", 32'(rsp_valid), 32'd1);
    cyc_pos();
    idle(5);

    // pointer wrap: bring ptr to 2, then requesters 3 and 1
    set_req(1, 5, 6);
    tick();
    idle(3);
    set_req(3, 7, 8);
    set_req(1, 9, 10);
    cyc_neg();
    check("wrap_grant_3", 32'(acc), 32'b1000);
    cyc_pos();
    cyc_neg();
    check("wrap_grant_1", 32'(acc), 32'b0010);
    cyc_pos();
    idle(3);
    for (int i = 0; i < N; i++) set_rand(i);
    cyc_neg();
    check("wrap_ptr_2", 32'(req_ready), 32'b0100);
    cyc_pos();
    idle(5);

    // randomized traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      tick();
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 9) < 6) set_rand(i);
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    rsp_ready = 1'b1;
    idle(6);
    check("sb_drained", 32'(sb.size()), 32'd0);

    // reset mid-stream with S1 and S2 full
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) set_rand(i);
    repeat (3) tick();
    check("mid_full", 32'(rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    req_valid = '0;
    #1;
    check("mid_rst_drop", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cyc_neg();
      check("mid_no_stale", 32'(rsp_valid), 32'd0);
      cyc_pos();
    end
    for (int i = 0; i < N; i++) set_rand(i);
    cyc_neg();
    check("mid_ptr_0", 32'(req_ready), 32'b0001);
    cyc_pos();
    idle(5);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
